// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared state enum and framing constants for the register dump reader.
// REG_DUMP_INDEX_EN adds a leading index byte (HDR state) to every register frame.
package reg_dump_pkg;
    localparam int BYTES_PER_WORD = 4;
`ifdef REG_DUMP_INDEX_EN
    localparam int FRAME_LEN = BYTES_PER_WORD + 1;
    typedef enum logic [2:0] {IDLE, LOAD, HDR, SEND, FIN} state_e;
`else
    localparam int FRAME_LEN = BYTES_PER_WORD;
    typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN} state_e;
`endif
endpackage

// File: rtl/reg_dump_shifter.sv
// reg_dump_shifter: 32-bit snapshot of one register, streamed out little-endian one byte per advance.
module reg_dump_shifter
    import reg_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        adv_i,
    input  logic [31:0] data_i,
    output logic [7:0]  byte_o,
    output logic        last_o
);
    localparam int CW = $clog2(BYTES_PER_WORD);
    logic [31:0]   shadow_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            shadow_q <= data_i;
            cnt_q    <= '0;
        end else if (adv_i) begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end
    assign byte_o = shadow_q[8*cnt_q +: 8];
    assign last_o = cnt_q == CW'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks registers FIRST_REG..LAST_REG through one read port and streams them as bytes.
// Define REG_DUMP_INDEX_EN to prefix each 4-byte frame with the register index.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rs_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte
);
    if (FIRST_REG > LAST_REG || FIRST_REG < 0 || LAST_REG > 31) begin : g_bad_range
        $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
    end
    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       load, adv, last;
    logic [7:0] sh_byte;
    reg_dump_shifter u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .adv_i  (adv),
        .data_i (rd_data),
        .byte_o (sh_byte),
        .last_o (last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                idx_d   = 5'(FIRST_REG);
            end
            LOAD: begin
                load = 1'b1;
`ifdef REG_DUMP_INDEX_EN
                state_d = HDR;
`else
                state_d = SEND;
`endif
            end
`ifdef REG_DUMP_INDEX_EN
            HDR: state_d = out_ready ? SEND : HDR;
`endif
            SEND: if (out_ready) begin
                adv = 1'b1;
                if (last) begin
                    state_d = idx_q == 5'(LAST_REG) ? FIN : LOAD;
                    idx_d   = idx_q == 5'(LAST_REG) ? idx_q : idx_q + 5'd1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // idx doubles as the registered read address: it already holds the next register at LOAD.
    assign rs_addr = idx_q;
    assign busy    = state_q != IDLE;
    assign done    = state_q == FIN;
`ifdef REG_DUMP_INDEX_EN
    assign out_valid = state_q == SEND || state_q == HDR;
    assign out_byte  = state_q == HDR ? {3'b000, idx_q} : state_q == SEND ? sh_byte : 8'h00;
`else
    assign out_valid = state_q == SEND;
    assign out_byte  = state_q == SEND ? sh_byte : 8'h00;
`endif
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: three dumpers (1..2, 0..31, 7..7) against a byte-list model of the register file.
// Honours REG_DUMP_INDEX_EN through reg_dump_pkg::FRAME_LEN.
module tb_reg_dump_reader;
    import reg_dump_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        done  [3];
    logic        ov    [3];
    logic [7:0]  ob    [3];
    logic [4:0]  ra    [3];
    logic [31:0] rd    [3];
    logic [31:0] regs  [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int first_r [3] = '{1, 0, 7};
    int last_r  [3] = '{2, 31, 7};
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    always_comb for (int k = 0; k < 3; k++) rd[k] = ra[k] == 5'd0 ? 32'h0 : regs[ra[k]];
    reg_dump_reader #(.FIRST_REG(1), .LAST_REG(2)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .rs_addr(ra[0]),
        .rd_data(rd[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_byte(ob[0]));
    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .rs_addr(ra[1]),
        .rd_data(rd[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_byte(ob[1]));
    reg_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]), .rs_addr(ra[2]),
        .rd_data(rd[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .out_byte(ob[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected stream: per register, optional index byte then the value low byte first; x0 reads 0.
    task automatic build_exp(input int k);
        logic [31:0] v;
        exp_q.delete();
        for (int r = first_r[k]; r <= last_r[k]; r++) begin
            v = r == 0 ? 32'h0 : regs[r];
            if (FRAME_LEN > BYTES_PER_WORD) exp_q.push_back(8'(r));
            for (int b = 0; b < 4; b++) exp_q.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic run_dump(input int k, input bit rnd, input int wr_at, input int wr_reg,
                            input logic [31:0] wr_val, input int abort_at, input bit busy_start);
        int c;
        bit pv, r;
        logic [7:0] pb;
        build_exp(k);
        got_q.delete();
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        check("busy_after_start", busy[k], 1);
        check("rs_addr_first", ra[k], first_r[k]);
        check("valid_low_in_load", ov[k], 0);
        c = 0;
        pv = 0;
        pb = 8'h00;
        while (!done[k] && c < 2000) begin
            if (pv) begin
                check("stall_valid", ov[k], 1);
                check("stall_byte", ob[k], pb);
            end
            if (abort_at >= 0 && got_q.size() == abort_at) break;
            if (wr_at >= 0 && got_q.size() == wr_at) regs[wr_reg] = wr_val;
            start[k] = busy_start && c == 2;
            r = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            rdy[k] = r;
            if (ov[k] && r) got_q.push_back(ob[k]);
            pv = ov[k] && !r;
            pb = ob[k];
            @(posedge clk); #1;
            c++;
        end
        rdy[k] = 1'b0;
        start[k] = 1'b0;
        if (abort_at >= 0) return;
        check("done_seen", done[k], 1);
        check("byte_count", got_q.size(), (last_r[k] - first_r[k] + 1) * FRAME_LEN);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("byte", got_q[i], exp_q[i]);
        if (!rnd) check("done_latency", c + 1, (last_r[k] - first_r[k] + 1) * (FRAME_LEN + 1) + 1);
        @(posedge clk); #1;
        check("done_one_cycle", done[k], 0);
        check("busy_low_after_done", busy[k], 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hFFFF_FFFF;
        regs[1] = 32'h1122_3344;
        regs[2] = 32'hDEAD_BEEF;
        regs[5] = 32'h5555_5555;
        regs[7] = 32'h0000_0102;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            rdy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", busy[k], 0);
            check("rst_done", done[k], 0);
            check("rst_valid", ov[k], 0);
            check("rst_byte", ob[k], 0);
            check("rst_addr", ra[k], 0);
        end
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        check("rst_beats_start", busy[0], 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_dump(0, 0, -1, 0, 32'h0, -1, 0);
        run_dump(0, 1, -1, 0, 32'h0, -1, 0);
        // x5 changes mid-frame; the snapshot taken at LOAD must be what goes out.
        run_dump(1, 0, 5 * FRAME_LEN + FRAME_LEN - 3, 5, 32'hAAAA_AAAA, -1, 0);
        run_dump(1, 1, -1, 0, 32'h0, 3 * FRAME_LEN + FRAME_LEN - 4 + 2, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", ov[1], 0);
        check("abort_busy", busy[1], 0);
        check("abort_byte", ob[1], 0);
        check("abort_addr", ra[1], 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", done[1], 0);
            @(posedge clk); #1;
        end
        run_dump(1, 1, -1, 0, 32'h0, -1, 0);
        run_dump(2, 0, -1, 0, 32'h0, -1, 1);
        for (int i = 0; i < 3; i++) begin
            check("start_not_queued", busy[2], 0);
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine that sits on the read side of the processor register file. On a start pulse it walks a contiguous range of architectural registers through one read port and captures each 32-bit value. It streams each value out as little-endian bytes over a valid/ready byte interface, which feeds the debug UART transmitter. It never writes the register file and only borrows one read-address port while busy.

## Interface
Parameters:
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped; FIRST_REG <= LAST_REG is required, otherwise elaboration fails.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; only sampled in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final byte is accepted.
- rs_addr  output  5  register-file read address; drive to Rs1 or Rs2 while busy.
- rd_data  input  32  register-file read data, combinational from rs_addr.
- out_valid  output  1  byte available.
- out_ready  input  1  sink accepts the byte when out_valid && out_ready at a rising edge.
- out_byte  output  8  stream byte.

## Operation
- States: IDLE, LOAD, HDR (only when the macro is set), SEND, FIN.
- IDLE → LOAD when start=1. Load idx=FIRST_REG; rs_addr=FIRST_REG registered; busy=1.
- LOAD: capture rd_data into a 32-bit shadow and set byte_cnt=0. Go to HDR if the macro is set, else SEND. out_valid=1 from the next cycle.
- HDR: out_byte={3'b000, idx}. On accept → SEND.
- SEND: out_byte=shadow[8*byte_cnt +: 8], byte 0 first.
  - On accept with byte_cnt<3: byte_cnt++.
  - On accept with byte_cnt==3 and idx<LAST_REG: idx++, rs_addr=idx+1, → LOAD, out_valid=0.
  - On accept with byte_cnt==3 and idx==LAST_REG: → FIN, out_valid=0.
- FIN: done=1 for one cycle, busy=0 next, → IDLE.
- The shadow is a snapshot. Register-file writes after the LOAD edge do not alter bytes in flight. A write that lands before LOAD is reflected.
- x0 reads as 0 and is dumped like any other register.
- start while busy is ignored and is not queued.
- Exactly 4*(LAST_REG-FIRST_REG+1) data bytes are emitted per dump.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_byte=8'h00, rs_addr=5'd0, state=IDLE.
- start high at edge N → busy=1 and rs_addr=FIRST_REG after N. Shadow captured at edge N+1. out_valid=1 after N+1.
- Per register: 1 LOAD bubble cycle plus 4 accept cycles (5 with header), given out_ready held high.
- Full dump of 0..31 with out_ready=1: start edge to done pulse is 161 cycles, or 193 with the header.
- While out_valid=1 && out_ready=0, out_byte and out_valid hold stable, with no retraction. out_valid is never asserted in IDLE, LOAD or FIN.
- out_ready is ignored when out_valid=0.
- rst mid-dump: all outputs return to reset values on the next edge, no done is issued, and the partial frame is discarded.
- rst and start in the same cycle: rst wins.

## Configuration
- REG_DUMP_INDEX_EN defined: each register frame is 5 bytes, {index byte, b0, b1, b2, b3}, and the HDR state exists.
- REG_DUMP_INDEX_EN undefined: frames are 4 bytes, HDR is compiled out, and LOAD goes straight to SEND.

## Structure
- Shared package reg_dump_pkg holds:
  - the state enum;
  - BYTES_PER_WORD=4;
  - the frame-length constant derived from REG_DUMP_INDEX_EN.
- Sub-module reg_dump_shifter is natural. It holds the 32-bit shadow, byte_cnt and the byte mux, with load/advance inputs and a last-byte flag. The top keeps the FSM and idx counter.

## Test plan
- Preload x1=32'h1122_3344 and x2=32'hDEAD_BEEF with FIRST=1, LAST=2, out_ready=1, then pulse start. Expect bytes 44 33 22 11 EF BE AD DE, done 11 cycles after the start edge, and busy low after done.
- Same dump with out_ready toggled 1/0 at random. Expect an identical byte sequence, out_byte stable across every stall, and no dropped or duplicated bytes.
- Full 0..31 dump with x0 written to 32'hFFFF_FFFF beforehand. Expect the first four bytes 00 00 00 00 and a total of 128 bytes.
- Write x5 to 32'hAAAA_AAAA during its SEND phase, having been 32'h5555_5555 at LOAD. Expect bytes 55 55 55 55.
- Assert rst during byte 2 of register 3. Expect out_valid=0, busy=0 next cycle and no done pulse. A new start restarts cleanly from FIRST_REG.
- With REG_DUMP_INDEX_EN, FIRST=LAST=7, x7=32'h0000_0102. Expect 07 02 01 00 00. Also check that a start pulse while busy is ignored.
